ap_ctrl_perf_monitor: RTL and testbench
=======================================

Name: ap_ctrl_perf_monitor

Overview:
- Synthesizable, parametrised monitor for NUM_CH HLS block-level handshakes (ap_start/ap_ready/ap_done/ap_continue).
- Per channel it records transaction count, last/min/max start-to-done latency, busy cycles and output-stall cycles.
- Sits beside the accelerator top level, snooping sub-block handshakes, and is read through a registered select/readout port. It is the hardware successor to the simulation-only CSV status monitors.

Parameters:
- NUM_CH, 4, number of monitored handshake channels (1..16)
- CNT_W, 32, width of every counter and of rd_data
- CH_W, $clog2(NUM_CH) min 1, width of rd_ch

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- mon_en  in  1  counters advance only while high; channel FSMs always track
- clear  in  1  synchronous clear of all channel state and counters
- finish  in  1  end-of-run; freezes all counters, sticky until reset/clear
- ap_start  in  NUM_CH  per-channel ap_start
- ap_ready  in  NUM_CH  per-channel ap_ready (counted only)
- ap_done  in  NUM_CH  per-channel ap_done
- ap_continue  in  NUM_CH  per-channel ap_continue (tie 1 for ap_ctrl_hs)
- rd_en  in  1  readout request
- rd_ch  in  CH_W  channel to read
- rd_sel  in  3  register select (see package)
- rd_valid  out  1  rd_data valid
- rd_data  out  CNT_W  selected register value
- ovf  out  NUM_CH  sticky per-channel counter-saturation flag
- busy  out  NUM_CH  channel FSM not IDLE

Behaviour:
- Reset (async, active-high): every FSM IDLE; all counters 0; min_lat all-ones; rd_valid=0; rd_data=0; ovf=0; frozen=0.
- Per-channel FSM:
  - IDLE -> RUN when ap_start=1. The latency counter loads 1 (the start cycle counts).
  - RUN: lat_cnt increments each cycle. On ap_done=1, latency is captured including the done cycle.
    - If ap_continue=1: update counters; ->IDLE.
    - Else: ->STALL.
  - IDLE with ap_start=1 and ap_done=1 in the same cycle: latency=1, and the transaction completes (or stalls) that cycle.
  - STALL: stall_cnt increments each cycle while ap_continue=0. On ap_continue=1 ->IDLE.
  - A new start is accepted only from IDLE. A start held high in the completion cycle begins a new transaction on the next cycle. At most one outstanding transaction per channel.
- Completion update, in the cycle the txn leaves RUN on done:
  - txn_cnt+1
  - last_lat=lat
  - min_lat=min(min_lat, lat)
  - max_lat=max(max_lat, lat)
- busy_cnt increments every cycle the FSM is RUN or STALL.
- ready_cnt increments every cycle ap_ready=1.
- Counters advance only when mon_en=1 and frozen=0. The FSM and lat_cnt always run, so latency stays correct across mon_en toggles.
- Saturation: every counter saturates at all-ones. Saturation of any counter sets ovf[ch], which stays set until reset/clear.
- finish=1 sets frozen. Frozen counters hold; readout still works.
- clear: every channel returns to reset values, including FSM->IDLE and frozen=0. clear wins over a simultaneous event in the same cycle; that event is dropped. A transaction in flight at clear is abandoned.
- Readout:
  - rd_en sampled at cycle N gives rd_valid=1 and rd_data at cycle N+1. rd_valid is 0 otherwise, and rd_data holds its last value.
  - rd_ch >= NUM_CH returns 0.
  - A read in the same cycle as an update returns the pre-update value.
- rd_sel values: 0 txn_cnt, 1 last_lat, 2 min_lat, 3 max_lat, 4 busy_cnt, 5 stall_cnt, 6 ready_cnt, 7 {ovf[ch], state, zero-padded} status.

Optional Feature:
- Macro: AP_CTRL_PERF_MONITOR_II_EN.
- Defined: each channel also measures the initiation interval, i.e. cycles between consecutive accepted starts.
  - last_ii and min_ii are kept; min_ii resets to all-ones.
  - They are exposed by widening rd_sel to 4 bits: 8 last_ii, 9 min_ii.
  - The first start after reset/clear records no II.
- Not defined: no II logic is built; rd_sel stays 3 bits.

Decomposition:
- Package perf_mon_pkg holds:
  - the ch_state_t enum {IDLE, RUN, STALL}
  - the rd_sel_t enum with encodings above
  - RD_SEL_W, which depends on the macro
  - a saturating-increment function
- Sub-module ap_ctrl_chan_monitor: one channel's FSM plus its counters, generated NUM_CH times. The top holds frozen, the readout mux and the output register.

Test Plan:
- Channel 0, start at cycle 10, done with continue=1 at cycle 14 -> txn_cnt=1, last_lat=min_lat=max_lat=5, busy_cnt=5.
- Channel 1, latencies 3, then 7, then 4 -> txn_cnt=3, min_lat=3, max_lat=7, last_lat=4.
- Channel 2, done at cycle 20 with continue=0 until cycle 23 -> stall_cnt=3, state STALL at 21, IDLE at 24. A start at 22 is ignored.
- Counter near saturation: busy_cnt preset via CNT_W=4 build, run 20 busy cycles -> busy_cnt=15, ovf[ch]=1; clear -> 0, ovf=0.
- finish pulse mid-transaction, then done -> txn_cnt unchanged. rd_en then rd_sel=0 -> rd_valid one cycle later with the frozen value. reset asserted mid-run -> all outputs return to reset values immediately.
- With AP_CTRL_PERF_MONITOR_II_EN defined: starts at cycles 5, 12, 16 -> last_ii=4, min_ii=4. Without the macro, rd_sel stays 3 bits.

Source files
------------

// File: rtl/ap_ctrl_perf_monitor_pkg.sv
// Shared types and helpers for the ap_ctrl performance monitor.
//   ch_state_t : per-channel handshake FSM state
//   rd_sel_t   : readout register select encodings
//   RD_SEL_W   : rd_sel width (4 when AP_CTRL_PERF_MONITOR_II_EN is defined, else 3)
//   sat_inc    : saturating increment on a w-bit value carried in 64 bits (w <= 64)
package perf_mon_pkg;

`ifdef AP_CTRL_PERF_MONITOR_II_EN
  localparam int RD_SEL_W = 4;
`else
  localparam int RD_SEL_W = 3;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } ch_state_t;

  typedef enum logic [RD_SEL_W-1:0] {
    SEL_TXN     = RD_SEL_W'(0),
    SEL_LAST    = RD_SEL_W'(1),
    SEL_MIN     = RD_SEL_W'(2),
    SEL_MAX     = RD_SEL_W'(3),
    SEL_BUSY    = RD_SEL_W'(4),
    SEL_STALL   = RD_SEL_W'(5),
    SEL_READY   = RD_SEL_W'(6),
    SEL_STATUS  = RD_SEL_W'(7)
`ifdef AP_CTRL_PERF_MONITOR_II_EN
    ,
    SEL_LAST_II = RD_SEL_W'(8),
    SEL_MIN_II  = RD_SEL_W'(9)
`endif
  } rd_sel_t;

  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] top;
    top = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= top) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/ap_ctrl_perf_monitor_if.sv
// Handshake snoop and readout bundle for ap_ctrl_perf_monitor.
//   ap_start/ap_ready/ap_done/ap_continue : per-channel HLS block handshakes
//   rd_en/rd_ch/rd_sel                    : readout request
//   rd_valid/rd_data                      : registered readout response
// master = driver of handshakes and requests, slave = the monitor.
interface ap_ctrl_perf_monitor_if
  import perf_mon_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [NUM_CH-1:0]   ap_start;
  logic [NUM_CH-1:0]   ap_ready;
  logic [NUM_CH-1:0]   ap_done;
  logic [NUM_CH-1:0]   ap_continue;
  logic                rd_en;
  logic [CH_W-1:0]     rd_ch;
  logic [RD_SEL_W-1:0] rd_sel;
  logic                rd_valid;
  logic [CNT_W-1:0]    rd_data;

  modport master (
    output ap_start, ap_ready, ap_done, ap_continue, rd_en, rd_ch, rd_sel,
    input  rd_valid, rd_data
  );

  modport slave (
    input  ap_start, ap_ready, ap_done, ap_continue, rd_en, rd_ch, rd_sel,
    output rd_valid, rd_data
  );
endinterface

// File: rtl/ap_ctrl_perf_monitor_chan.sv
// ap_ctrl_chan_monitor: one channel's handshake FSM and its counters.
//   clock, reset (async high), clear (sync), cnt_en (counters may advance)
//   start/ready/done/cont : this channel's ap_* handshake bits
//   state                 : FSM state
//   txn_cnt..ready_cnt    : saturating statistics, ovf sticky on a lost count
//   last_ii/min_ii        : only with AP_CTRL_PERF_MONITOR_II_EN
// The FSM and the latency counter run regardless of cnt_en so a latency
// straddling a mon_en gap is still measured correctly. CNT_W must be 4..64.
module ap_ctrl_chan_monitor
  import perf_mon_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             cnt_en,
  input  logic             start,
  input  logic             ready,
  input  logic             done,
  input  logic             cont,
  output ch_state_t        state,
  output logic [CNT_W-1:0] txn_cnt,
  output logic [CNT_W-1:0] last_lat,
  output logic [CNT_W-1:0] min_lat,
  output logic [CNT_W-1:0] max_lat,
  output logic [CNT_W-1:0] busy_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] ready_cnt,
`ifdef AP_CTRL_PERF_MONITOR_II_EN
  output logic [CNT_W-1:0] last_ii,
  output logic [CNT_W-1:0] min_ii,
`endif
  output logic             ovf
);
  localparam logic [CNT_W-1:0] ONES = '1;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
    logic [63:0] r;
    r = sat_inc(64'(v), CNT_W);
    return r[CNT_W-1:0];
  endfunction

  ch_state_t        state_d;
  logic [CNT_W-1:0] lat_q, lat_d, lat_now;
  logic             accept, complete, stalling, busy_cyc, sat_hit;

  always_comb begin
    state_d  = state;
    lat_d    = lat_q;
    lat_now  = inc(lat_q);
    accept   = 1'b0;
    complete = 1'b0;
    case (state)
      IDLE: if (start) begin
        // start cycle counts as latency 1; done in the same cycle completes it
        accept  = 1'b1;
        lat_now = ONE;
        lat_d   = ONE;
        state_d = RUN;
        if (done) begin
          complete = 1'b1;
          state_d  = cont ? IDLE : STALL;
        end
      end
      RUN: begin
        lat_d = lat_now;
        if (done) begin
          complete = 1'b1;
          state_d  = cont ? IDLE : STALL;
        end
      end
      STALL:   if (cont) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // the done cycle itself is a stall cycle when continue is low
    stalling = (complete || state == STALL) && !cont;
    busy_cyc = accept || (state != IDLE);
    sat_hit  = (complete && txn_cnt == ONES) || (busy_cyc && busy_cnt == ONES) ||
               (stalling && stall_cnt == ONES) || (ready && ready_cnt == ONES) ||
               (state == RUN && lat_q == ONES);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE; lat_q <= '0; txn_cnt <= '0; last_lat <= '0; min_lat <= ONES;
      max_lat <= '0; busy_cnt <= '0; stall_cnt <= '0; ready_cnt <= '0; ovf <= 1'b0;
    end else if (clear) begin
      state <= IDLE; lat_q <= '0; txn_cnt <= '0; last_lat <= '0; min_lat <= ONES;
      max_lat <= '0; busy_cnt <= '0; stall_cnt <= '0; ready_cnt <= '0; ovf <= 1'b0;
    end else begin
      state <= state_d;
      lat_q <= lat_d;
      if (cnt_en) begin
        if (complete) begin
          txn_cnt  <= inc(txn_cnt);
          last_lat <= lat_now;
          if (lat_now < min_lat) min_lat <= lat_now;
          if (lat_now > max_lat) max_lat <= lat_now;
        end
        if (busy_cyc) busy_cnt  <= inc(busy_cnt);
        if (stalling) stall_cnt <= inc(stall_cnt);
        if (ready)    ready_cnt <= inc(ready_cnt);
        if (sat_hit)  ovf       <= 1'b1;
      end
    end
  end

`ifdef AP_CTRL_PERF_MONITOR_II_EN
  // ii_q counts cycles since the previous accepted start; the first start
  // after reset/clear only arms it
  logic [CNT_W-1:0] ii_q;
  logic             ii_seen;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ii_q <= '0; ii_seen <= 1'b0; last_ii <= '0; min_ii <= ONES;
    end else if (clear) begin
      ii_q <= '0; ii_seen <= 1'b0; last_ii <= '0; min_ii <= ONES;
    end else if (accept) begin
      ii_q    <= ONE;
      ii_seen <= 1'b1;
      if (ii_seen && cnt_en) begin
        last_ii <= ii_q;
        if (ii_q < min_ii) min_ii <= ii_q;
      end
    end else if (ii_seen) begin
      ii_q <= inc(ii_q);
    end
  end
`endif

endmodule

// File: rtl/ap_ctrl_perf_monitor.sv
// ap_ctrl_perf_monitor: per-channel HLS handshake statistics with a
// registered readout port.
//   clock, reset (async high), mon_en, clear, finish (sticky freeze)
//   bus  : ap_ctrl_perf_monitor_if.slave (handshakes + readout)
//   ovf  : sticky per-channel saturation flags
//   busy : per-channel FSM not IDLE
// Optional: AP_CTRL_PERF_MONITOR_II_EN adds last_ii/min_ii readout (rd_sel 8/9).
module ap_ctrl_perf_monitor
  import perf_mon_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 mon_en,
  input  logic                 clear,
  input  logic                 finish,
  ap_ctrl_perf_monitor_if.slave bus,
  output logic [NUM_CH-1:0]    ovf,
  output logic [NUM_CH-1:0]    busy
);
  logic frozen, cnt_en;
  // the finish cycle itself is already frozen
  assign cnt_en = mon_en & ~frozen & ~finish;

  ch_state_t                     st [NUM_CH];
  logic [NUM_CH-1:0][CNT_W-1:0]  txn, last, mn, mx, bsy, stl, rdy;
`ifdef AP_CTRL_PERF_MONITOR_II_EN
  logic [NUM_CH-1:0][CNT_W-1:0]  lii, mii;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ap_ctrl_chan_monitor #(.CNT_W(CNT_W)) u_chan (
      .clock    (clock),
      .reset    (reset),
      .clear    (clear),
      .cnt_en   (cnt_en),
      .start    (bus.ap_start[c]),
      .ready    (bus.ap_ready[c]),
      .done     (bus.ap_done[c]),
      .cont     (bus.ap_continue[c]),
      .state    (st[c]),
      .txn_cnt  (txn[c]),
      .last_lat (last[c]),
      .min_lat  (mn[c]),
      .max_lat  (mx[c]),
      .busy_cnt (bsy[c]),
      .stall_cnt(stl[c]),
      .ready_cnt(rdy[c]),
`ifdef AP_CTRL_PERF_MONITOR_II_EN
      .last_ii  (lii[c]),
      .min_ii   (mii[c]),
`endif
      .ovf      (ovf[c])
    );
    assign busy[c] = (st[c] != IDLE);
  end

  // channel match loop: an out-of-range rd_ch matches nothing and reads 0
  logic [CNT_W-1:0] rd_mux;
  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.rd_ch == CH_W'(c)) begin
        case (bus.rd_sel)
          SEL_TXN:     rd_mux = txn[c];
          SEL_LAST:    rd_mux = last[c];
          SEL_MIN:     rd_mux = mn[c];
          SEL_MAX:     rd_mux = mx[c];
          SEL_BUSY:    rd_mux = bsy[c];
          SEL_STALL:   rd_mux = stl[c];
          SEL_READY:   rd_mux = rdy[c];
          SEL_STATUS:  rd_mux = CNT_W'({ovf[c], st[c]});
`ifdef AP_CTRL_PERF_MONITOR_II_EN
          SEL_LAST_II: rd_mux = lii[c];
          SEL_MIN_II:  rd_mux = mii[c];
`endif
          default:     rd_mux = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
      frozen       <= 1'b0;
    end else begin
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en) bus.rd_data <= rd_mux;
      if (clear)       frozen <= 1'b0;
      else if (finish) frozen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
`timescale 1ns/1ps
module tb_ap_ctrl_perf_monitor;
  import perf_mon_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic mon_en = 1'b1, clear = 1'b0, finish = 1'b0, clear1 = 1'b0;
  logic [3:0] ovf0, busy0;
  logic [0:0] ovf1, busy1;
  always #5 clock = ~clock;

  ap_ctrl_perf_monitor_if #(.NUM_CH(4), .CNT_W(32)) bus0 ();
  ap_ctrl_perf_monitor_if #(.NUM_CH(1), .CNT_W(4))  bus1 ();

  ap_ctrl_perf_monitor #(.NUM_CH(4), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .mon_en(mon_en), .clear(clear), .finish(finish),
    .bus(bus0), .ovf(ovf0), .busy(busy0));

  ap_ctrl_perf_monitor #(.NUM_CH(1), .CNT_W(4)) dut_sat (
    .clock(clock), .reset(reset), .mon_en(1'b1), .clear(clear1), .finish(1'b0),
    .bus(bus1), .ovf(ovf1), .busy(busy1));

  int n_run = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  typedef struct { string tag; logic [31:0] exp; } exp_t;
  exp_t q0[$], q1[$];

  // bench-side model of the main instance, built from transaction shapes
  logic [31:0] m_txn[4], m_last[4], m_min[4], m_max[4], m_busy[4], m_stall[4], m_ready[4];

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_txn[i] = 0; m_last[i] = 0; m_min[i] = '1; m_max[i] = 0;
      m_busy[i] = 0; m_stall[i] = 0; m_ready[i] = 0;
    end
  endtask

  task automatic model_done(input int ch, input int lat, input int bsy, input int stl);
    m_txn[ch]++;
    m_last[ch] = lat;
    if (lat < m_min[ch]) m_min[ch] = lat;
    if (lat > m_max[ch]) m_max[ch] = lat;
    m_busy[ch] += bsy;
    m_stall[ch] += stl;
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clock);
      bus0.rd_en = 1'b0;
      bus1.rd_en = 1'b0;
    end
  endtask

  task automatic rd0(input int ch, input rd_sel_t sel, input logic [31:0] exp, input string tag);
    bus0.rd_en = 1'b1; bus0.rd_ch = 2'(ch); bus0.rd_sel = sel;
    q0.push_back('{tag, exp});
  endtask

  task automatic rd1(input int ch, input rd_sel_t sel, input logic [31:0] exp, input string tag);
    bus1.rd_en = 1'b1; bus1.rd_ch = 1'(ch); bus1.rd_sel = sel;
    q1.push_back('{tag, exp});
  endtask

  // one transaction on the main instance: lat cycles start..done, then stl
  // stall cycles counted from the done cycle
  task automatic txn(input int ch, input int lat, input int stl);
    bus0.ap_continue[ch] = (stl == 0);
    bus0.ap_start[ch] = 1'b1;
    if (lat == 1) bus0.ap_done[ch] = 1'b1;
    else begin
      tick(); bus0.ap_start[ch] = 1'b0;
      tick(lat - 2); bus0.ap_done[ch] = 1'b1;
    end
    tick(); bus0.ap_start[ch] = 1'b0; bus0.ap_done[ch] = 1'b0;
    if (stl > 0) begin
      tick(stl - 1); bus0.ap_continue[ch] = 1'b1; tick();
    end
    model_done(ch, lat, lat + stl, stl);
  endtask

  task automatic check_ch(input int ch);
    rd0(ch, SEL_TXN,   m_txn[ch],   $sformatf("ch%0d_txn", ch));   tick();
    rd0(ch, SEL_LAST,  m_last[ch],  $sformatf("ch%0d_last", ch));  tick();
    rd0(ch, SEL_MIN,   m_min[ch],   $sformatf("ch%0d_min", ch));   tick();
    rd0(ch, SEL_MAX,   m_max[ch],   $sformatf("ch%0d_max", ch));   tick();
    rd0(ch, SEL_BUSY,  m_busy[ch],  $sformatf("ch%0d_busy", ch));  tick();
    rd0(ch, SEL_STALL, m_stall[ch], $sformatf("ch%0d_stall", ch)); tick();
    rd0(ch, SEL_READY, m_ready[ch], $sformatf("ch%0d_ready", ch)); tick();
  endtask

  always @(negedge clock) begin : mon0
    exp_t e;
    if (!reset && bus0.rd_valid) begin
      if (q0.size() == 0) chk("rd0_spurious_valid", 1, 0);
      else begin e = q0.pop_front(); chk(e.tag, 64'(bus0.rd_data), 64'(e.exp)); end
    end
  end

  always @(negedge clock) begin : mon1
    exp_t e;
    if (!reset && bus1.rd_valid) begin
      if (q1.size() == 0) chk("rd1_spurious_valid", 1, 0);
      else begin e = q1.pop_front(); chk(e.tag, 64'(bus1.rd_data), 64'(e.exp)); end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus0.ap_start = '0; bus0.ap_ready = '0; bus0.ap_done = '0; bus0.ap_continue = '1;
    bus0.rd_en = 1'b0; bus0.rd_ch = '0; bus0.rd_sel = SEL_TXN;
    bus1.ap_start = '0; bus1.ap_ready = '0; bus1.ap_done = '0; bus1.ap_continue = '1;
    bus1.rd_en = 1'b0; bus1.rd_ch = '0; bus1.rd_sel = SEL_TXN;
    model_clear();

    // reset state
    tick(3);
    chk("rst_rd_valid", bus0.rd_valid, 0);
    chk("rst_rd_data", bus0.rd_data, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_ovf", ovf0, 0);
    reset = 1'b0;
    tick(2);
    rd0(0, SEL_MIN, 32'hFFFF_FFFF, "rst_min_lat"); tick();
    rd0(0, SEL_STATUS, 0, "rst_status"); tick();
    rd0(3, SEL_TXN, 0, "rst_txn"); tick();

    // ch0: single transaction latency 5
    txn(0, 5, 0);
    chk("ch0_busy_after", busy0[0], 0);
    // ch1: latencies 3, 7, 4
    txn(1, 3, 0); txn(1, 7, 0); txn(1, 4, 0);

    // ch2: done with continue low, start during stall must be ignored
    bus0.ap_continue[2] = 1'b0; bus0.ap_start[2] = 1'b1; tick();
    bus0.ap_start[2] = 1'b0; bus0.ap_done[2] = 1'b1; tick();
    bus0.ap_done[2] = 1'b0;
    chk("ch2_busy_stall", busy0[2], 1);
    rd0(2, SEL_STATUS, 32'd2, "ch2_status_stall");
    bus0.ap_start[2] = 1'b1; tick();
    bus0.ap_start[2] = 1'b0; tick();
    chk("ch2_busy_stall2", busy0[2], 1);
    bus0.ap_continue[2] = 1'b1; tick();
    chk("ch2_busy_idle", busy0[2], 0);
    model_done(2, 2, 5, 3);

    // ch3: ready counting, latency-1 transaction, mon_en gap
    bus0.ap_ready[3] = 1'b1; tick(4); bus0.ap_ready[3] = 1'b0;
    m_ready[3] = 4;
    txn(3, 1, 0);
    bus0.ap_start[3] = 1'b1; tick();
    bus0.ap_start[3] = 1'b0; mon_en = 1'b0; bus0.ap_ready[3] = 1'b1; tick();
    bus0.ap_ready[3] = 1'b0; tick();
    mon_en = 1'b1; bus0.ap_done[3] = 1'b1; tick();
    bus0.ap_done[3] = 1'b0;
    model_done(3, 4, 2, 0);

    // ch0: read in the completion cycle sees the pre-update value
    bus0.ap_start[0] = 1'b1; tick();
    bus0.ap_start[0] = 1'b0; bus0.ap_done[0] = 1'b1;
    rd0(0, SEL_TXN, 1, "ch0_txn_preupd"); tick();
    bus0.ap_done[0] = 1'b0;
    model_done(0, 2, 2, 0);

    for (int c = 0; c < 4; c++) check_ch(c);

    // finish mid-transaction on ch1 freezes counters
    bus0.ap_start[1] = 1'b1; tick();
    bus0.ap_start[1] = 1'b0; tick();
    finish = 1'b1; tick(); finish = 1'b0; tick();
    bus0.ap_done[1] = 1'b1; tick(); bus0.ap_done[1] = 1'b0;
    rd0(1, SEL_TXN, 3, "fin_txn"); tick();
    chk("fin_rd_valid_n1", bus0.rd_valid, 1);
    tick();
    chk("fin_rd_valid_n2", bus0.rd_valid, 0);
    chk("fin_rd_data_hold", bus0.rd_data, 3);
    rd0(1, SEL_LAST, 4, "fin_last"); tick();

    // clear returns everything to reset values and unfreezes
    clear = 1'b1; tick(); clear = 1'b0;
    model_clear();
    rd0(1, SEL_TXN, 0, "clr_txn1"); tick();
    rd0(1, SEL_MIN, 32'hFFFF_FFFF, "clr_min1"); tick();
    rd0(2, SEL_STALL, 0, "clr_stall2"); tick();
    txn(0, 3, 0);
    rd0(0, SEL_TXN, 1, "clr_txn0_after"); tick();
    rd0(0, SEL_LAST, 3, "clr_last0_after"); tick();

    // reset asserted mid-run clears outputs immediately
    bus0.ap_start[0] = 1'b1;
    rd0(1, SEL_MIN, 32'hFFFF_FFFF, "pre_rst_min");
    @(posedge clock); #2;
    chk("pre_rst_busy", busy0[0], 1);
    chk("pre_rst_valid", bus0.rd_valid, 1);
    reset = 1'b1; #1;
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_valid", bus0.rd_valid, 0);
    chk("mid_rst_data", bus0.rd_data, 0);
    chk("mid_rst_ovf", ovf0, 0);
    bus0.ap_start[0] = 1'b0;
    q0.delete();
    tick(2); reset = 1'b0; tick();
    model_clear();
    rd0(0, SEL_TXN, 0, "post_rst_txn"); tick();

    // saturation on the CNT_W=4 instance: 20 busy cycles
    bus1.ap_start[0] = 1'b1; tick();
    bus1.ap_start[0] = 1'b0; tick(18);
    bus1.ap_done[0] = 1'b1; tick(); bus1.ap_done[0] = 1'b0;
    chk("sat_ovf", ovf1, 1);
    rd1(0, SEL_BUSY, 15, "sat_busy"); tick();
    rd1(0, SEL_TXN, 1, "sat_txn"); tick();
    rd1(0, SEL_LAST, 15, "sat_last"); tick();
    rd1(0, SEL_STATUS, 4, "sat_status"); tick();
    rd1(1, SEL_BUSY, 0, "sat_ch_oob"); tick();
    clear1 = 1'b1; tick(); clear1 = 1'b0;
    chk("sat_clr_ovf", ovf1, 0);
    rd1(0, SEL_BUSY, 0, "sat_clr_busy"); tick();
    rd1(0, SEL_MIN, 15, "sat_clr_min"); tick();

`ifdef AP_CTRL_PERF_MONITOR_II_EN
    // starts 7 then 4 cycles apart
    txn(0, 1, 0); tick(6);
    txn(0, 1, 0); tick(3);
    txn(0, 1, 0);
    rd0(0, SEL_LAST_II, 4, "ii_last"); tick();
    rd0(0, SEL_MIN_II, 4, "ii_min"); tick();
`endif

    tick(4);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
